// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data requesters, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with data winning ties.
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | no owner; pick a winner among pending requests
    // ADDR  | owner's request presented on the memory port, waiting for mem_addr_ok
    // DATA  | request accepted, waiting for mem_data_ok to route back to the owner
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;   // 0 = inst, 1 = data
    logic   owner_req;
    logic   win_data;

`ifdef ARB_RR_EN
    logic last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win_data = data_req;
        if (data_req && inst_req) begin
            win_data = ~last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && (data_req || inst_req)) begin
            last_grant <= win_data;
        end
    end
`else
    assign win_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    assign owner_req = owner ? data_req : inst_req;

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        mem_req      = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            IDLE: begin
                if (data_req || inst_req) begin
                    owner_nxt = win_data;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                mem_req      = owner_req;
                inst_addr_ok = ~owner & owner_req & mem_addr_ok;
                data_addr_ok =  owner & owner_req & mem_addr_ok;
                // A dropped request before acceptance is a cancel; nothing was issued.
                if (!owner_req) begin
                    state_nxt = IDLE;
                end else if (mem_addr_ok) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                inst_data_ok = ~owner & mem_data_ok;
                data_data_ok =  owner & mem_data_ok;
                if (mem_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_wr     = owner ? data_wr    : inst_wr;
    assign mem_size   = owner ? data_size  : inst_size;
    assign mem_addr   = owner ? data_addr  : inst_addr;
    assign mem_wdata  = owner ? data_wdata : inst_wdata;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed requests, a stall-programmable memory responder and a queue-based monitor.
// Grant-order expectations follow ARB_RR_EN when the bench is built with it.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } addr_exp_t;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } data_exp_t;

    addr_exp_t   addr_q[$];
    data_exp_t   data_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          addr_stall = 0;
    int          data_stall = 1;
    logic [31:0] rd_val = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic req, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        inst_req = req; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wdata;
    endtask

    task automatic set_data(input logic req, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        data_req = req; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    endtask

    task automatic expect_txn(input logic owner, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input bit with_data);
        addr_exp_t ea;
        data_exp_t ed;
        ea.owner = owner; ea.wr = wr; ea.size = size; ea.addr = addr; ea.wdata = wdata;
        addr_q.push_back(ea);
        if (with_data) begin
            ed.owner = owner; ed.rdata = rdata;
            data_q.push_back(ed);
        end
    endtask

    // Returns one cycle after the accepting handshake, i.e. early in the first DATA cycle.
    task automatic wait_accept(input string name, output int polls, output int gaps);
        bit seen = 0;
        polls = 0;
        gaps = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            polls++;
            if (mem_req) seen = 1;
            else if (seen) gaps++;
            if (mem_req && mem_addr_ok) begin
                tick();
                return;
            end
        end
        timeout({name, "_accept"});
    endtask

    task automatic wait_done(input string name, output int polls);
        polls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            polls++;
            if (inst_data_ok || data_data_ok) begin
                tick();
                return;
            end
        end
        timeout({name, "_done"});
    endtask

    // Downstream model: mem_addr_ok after addr_stall cycles of mem_req, mem_data_ok data_stall cycles later.
    initial begin : responder
        int   phase;
        int   cnt;
        logic req_seen;
        phase = 0;
        cnt = 0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            req_seen = mem_req;
            @(posedge clk);
            #1;
            case (phase)
                0: begin
                    if (req_seen === 1'b1 && mem_addr_ok) begin
                        mem_addr_ok = 1'b0;
                        cnt = 0;
                        if (data_stall == 0) begin
                            mem_data_ok = 1'b1; mem_rdata = rd_val; phase = 2;
                        end else begin
                            phase = 1;
                        end
                    end else if (req_seen === 1'b1) begin
                        cnt++;
                        mem_addr_ok = (cnt >= addr_stall);
                    end else begin
                        cnt = 0;
                        mem_addr_ok = (addr_stall == 0);
                    end
                end
                1: begin
                    cnt++;
                    if (cnt >= data_stall) begin
                        mem_data_ok = 1'b1; mem_rdata = rd_val; phase = 2;
                    end
                end
                default: begin
                    mem_data_ok = 1'b0;
                    mem_rdata = '0;
                    cnt = 0;
                    phase = 0;
                    mem_addr_ok = (addr_stall == 0);
                end
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        addr_exp_t ea;
        data_exp_t ed;
        if (reset === 1'b0) begin
            if (mem_req && mem_addr_ok) begin
                if (addr_q.size() == 0) begin
                    timeout("unexpected_accept");
                end else begin
                    ea = addr_q.pop_front();
                    chk("addr_ok_owner", 32'({inst_addr_ok, data_addr_ok}),
                        ea.owner ? 32'h1 : 32'h2);
                    chk("mem_wr", 32'(mem_wr), 32'(ea.wr));
                    chk("mem_size", 32'(mem_size), 32'(ea.size));
                    chk("mem_addr", mem_addr, ea.addr);
                    if (ea.wr) chk("mem_wdata", mem_wdata, ea.wdata);
                end
            end else begin
                chk("spurious_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'h0);
            end
            if (inst_data_ok || data_data_ok) begin
                if (data_q.size() == 0) begin
                    chk("spurious_data_ok", 32'({inst_data_ok, data_data_ok}), 32'h0);
                end else begin
                    ed = data_q.pop_front();
                    chk("data_ok_owner", 32'({inst_data_ok, data_data_ok}),
                        ed.owner ? 32'h1 : 32'h2);
                    chk("rdata", ed.owner ? data_rdata : inst_rdata, ed.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   polls;
        int   gaps;
        int   dpolls;
        logic o;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
        chk("reset_data_addr_ok", 32'(data_addr_ok), 32'h0);
        chk("reset_inst_data_ok", 32'(inst_data_ok), 32'h0);
        chk("reset_data_data_ok", 32'(data_data_ok), 32'h0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Single instruction read: accept on the first mem_req cycle, response two cycles later
        addr_stall = 0; data_stall = 1; rd_val = 32'h3C010001;
        expect_txn(1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0, 32'h3C010001, 1);
        set_inst(1'b1, 1'b0, 2'd2, 32'hBFC00000, 32'h0);
        wait_accept("single", polls, gaps);
        chk("single_accept_latency", 32'(polls), 32'd2);
        inst_req = 1'b0;
        wait_done("single", dpolls);
        chk("single_data_latency", 32'(dpolls), 32'd2);

        // Tie: data write wins, instruction read follows on the next IDLE
        rd_val = 32'h0;
        expect_txn(1'b1, 1'b1, 2'd2, 32'h00001000, 32'hDEADBEEF, 32'h0, 1);
        expect_txn(1'b0, 1'b0, 2'd2, 32'hBFC00004, 32'h0, 32'h24020005, 1);
        set_data(1'b1, 1'b1, 2'd2, 32'h00001000, 32'hDEADBEEF);
        set_inst(1'b1, 1'b0, 2'd2, 32'hBFC00004, 32'h0);
        wait_accept("tie_data", polls, gaps);
        data_req = 1'b0;
        wait_done("tie_data", dpolls);
        rd_val = 32'h24020005;
        wait_accept("tie_inst", polls, gaps);
        inst_req = 1'b0;
        wait_done("tie_inst", dpolls);

        // Both requesters held high for four transactions
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            o = (i % 2 == 0);
`else
            o = 1'b1;
`endif
            expect_txn(o, 1'b0, 2'd2, o ? 32'h00005000 : 32'hBFC00008, 32'h0,
                       32'hA0A00000 + 32'(i), 1);
        end
        set_data(1'b1, 1'b0, 2'd2, 32'h00005000, 32'h0);
        set_inst(1'b1, 1'b0, 2'd2, 32'hBFC00008, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd_val = 32'hA0A00000 + 32'(i);
            wait_accept("hold", polls, gaps);
            if (i == 3) begin
                data_req = 1'b0;
                inst_req = 1'b0;
            end
            wait_done("hold", dpolls);
        end

        // Stalls: 5 cycles without mem_addr_ok, response 7 cycles into DATA; inst waits throughout
        addr_stall = 5; data_stall = 7; rd_val = 32'h0;
        expect_txn(1'b1, 1'b1, 2'd1, 32'h00002002, 32'h0000CAFE, 32'h0, 1);
        expect_txn(1'b0, 1'b0, 2'd0, 32'hBFC0000C, 32'h0, 32'h000000AB, 1);
        set_data(1'b1, 1'b1, 2'd1, 32'h00002002, 32'h0000CAFE);
        set_inst(1'b1, 1'b0, 2'd0, 32'hBFC0000C, 32'h0);
        wait_accept("stall", polls, gaps);
        chk("stall_accept_cycles", 32'(polls), 32'd7);
        chk("stall_req_gaps", 32'(gaps), 32'd0);
        data_req = 1'b0;
        wait_done("stall", dpolls);
        chk("stall_data_cycles", 32'(dpolls), 32'd8);
        rd_val = 32'h000000AB;
        wait_accept("stall_inst", polls, gaps);
        inst_req = 1'b0;
        wait_done("stall_inst", dpolls);
        addr_stall = 0; data_stall = 1;
        repeat (2) tick();

        // Cancel: instruction request dropped while still waiting for acceptance
        addr_stall = 10;
        tick();
        set_inst(1'b1, 1'b0, 2'd2, 32'hBFC00010, 32'h0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("cancel_req_up", 32'(mem_req), 32'h1);
        chk("cancel_no_addr_ok", 32'(inst_addr_ok), 32'h0);
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        chk("cancel_req_down", 32'(mem_req), 32'h0);
        tick();
        addr_stall = 0; rd_val = 32'h11112222;
        expect_txn(1'b1, 1'b0, 2'd2, 32'h00003000, 32'h0, 32'h11112222, 1);
        set_data(1'b1, 1'b0, 2'd2, 32'h00003000, 32'h0);
        wait_accept("after_cancel", polls, gaps);
        chk("after_cancel_latency", 32'(polls), 32'd2);
        data_req = 1'b0;
        wait_done("after_cancel", dpolls);

        // Reset while in DATA: the late mem_data_ok must not reach the requester
        data_stall = 6; rd_val = 32'h99999999;
        expect_txn(1'b1, 1'b0, 2'd2, 32'h00004000, 32'h0, 32'h0, 0);
        set_data(1'b1, 1'b0, 2'd2, 32'h00004000, 32'h0);
        wait_accept("rst_data", polls, gaps);
        data_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_drop_data_ok", 32'({inst_data_ok, data_data_ok}), 32'h0);
        end
        tick();
        data_stall = 1; rd_val = 32'h0BADF00D;
        expect_txn(1'b0, 1'b0, 2'd2, 32'hBFC00020, 32'h0, 32'h0BADF00D, 1);
        set_inst(1'b1, 1'b0, 2'd2, 32'hBFC00020, 32'h0);
        wait_accept("after_rst", polls, gaps);
        chk("after_rst_latency", 32'(polls), 32'd2);
        inst_req = 1'b0;
        wait_done("after_rst", dpolls);

        repeat (3) tick();
        chk("addr_queue_empty", 32'(addr_q.size()), 32'h0);
        chk("data_queue_empty", 32'(data_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
